// File: rtl/drop_scanner_pkg.sv
// Shared definitions for the drop scanner: board defaults, 4x4 mask layout,
// scan FSM encoding and the game-level state codes used around it.
package drop_scanner_pkg;

  localparam int COLS_DEF  = 10;
  localparam int ROWS_DEF  = 20;

  // Mask bit 4*r+c covers the cell r rows below and c columns right of the anchor.
  localparam int MASK_DIM  = 4;
  localparam int MASK_BITS = MASK_DIM * MASK_DIM;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_STEP  = 2'd2,
    S_DONE  = 2'd3
  } scan_state_e;

  typedef enum logic [2:0] {
    GS_IDLE  = 3'd0,
    GS_SPAWN = 3'd1,
    GS_FALL  = 3'd2,
    GS_LOCK  = 3'd3,
    GS_CLEAR = 3'd4,
    GS_OVER  = 3'd5
  } game_state_e;

  function automatic int mask_bit(input int r, input int c);
    return r * MASK_DIM + c;
  endfunction

endpackage

// File: rtl/drop_scanner_piece_fit_check.sv
// Combinational fit test of a 4x4 piece mask at (row, col) against a board map.
// A set cell collides when below the floor, above the top, past the right edge or occupied.
module piece_fit_check
  import drop_scanner_pkg::*;
#(
  parameter int COLS  = COLS_DEF,
  parameter int ROWS  = ROWS_DEF,
  parameter int ROW_W = $clog2(ROWS),
  parameter int COL_W = $clog2(COLS)
) (
  input  logic [MASK_BITS-1:0]  i_mask,
  input  logic signed [ROW_W:0] i_row,
  input  logic [COL_W-1:0]      i_col,
  input  logic [COLS*ROWS-1:0]  i_map,
  output logic                  o_fits
);

  localparam int IDX_W = $clog2(COLS * ROWS);

  logic [MASK_BITS-1:0] w_hit;

  for (genvar r = 0; r < MASK_DIM; r++) begin : g_row
    for (genvar c = 0; c < MASK_DIM; c++) begin : g_col
      localparam int K = mask_bit(r, c);
      int   w_cr;
      int   w_cc;
      logic w_cell_hit;

      always_comb begin
        w_cr       = int'(i_row) - r;
        w_cc       = int'(i_col) + c;
        w_cell_hit = 1'b0;
        if (i_mask[K]) begin
          if (w_cr < 0 || w_cr >= ROWS || w_cc >= COLS) w_cell_hit = 1'b1;
          else w_cell_hit = i_map[IDX_W'(w_cr * COLS + w_cc)];
        end
      end

      assign w_hit[K] = w_cell_hit;
    end
  end

  assign o_fits = ~|w_hit;

endmodule

// File: rtl/drop_scanner.sv
// Hard-drop / ghost-preview scanner: latches a piece and board snapshot, then
// walks the piece down one row per cycle until the next row would collide.
module drop_scanner
  import drop_scanner_pkg::*;
#(
  parameter  int COLS  = COLS_DEF,
  parameter  int ROWS  = ROWS_DEF,
  localparam int ROW_W = $clog2(ROWS),
  localparam int COL_W = $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mode,
  input  logic [COLS*ROWS-1:0] blocks_exist,
  input  logic [15:0]          piece_mask,
  input  logic [ROW_W-1:0]     anchor_row,
  input  logic [COL_W-1:0]     anchor_col,
  output logic                 busy,
  output logic                 done,
  output logic                 blocked,
  output logic [ROW_W-1:0]     result_row,
  output logic [ROW_W-1:0]     drop_rows,
  output logic                 result_mode
);

  scan_state_e r_state, w_state_nxt;

  logic [MASK_BITS-1:0]  r_mask;
  logic [COL_W-1:0]      r_col;
  logic [COLS*ROWS-1:0]  r_map;
  logic                  r_mode;
  logic [ROW_W-1:0]      r_cur_row;
  logic [ROW_W-1:0]      r_drop;

  logic                  r_blocked;
  logic [ROW_W-1:0]      r_result_row;
  logic [ROW_W-1:0]      r_drop_rows;
  logic                  r_result_mode;

  logic                  w_load;
  logic                  w_step;
  logic                  w_fin;
  logic                  w_fin_blk;
  logic                  w_fits;
  logic signed [ROW_W:0] w_fit_row;

  // CHECK tests the start row itself; STEP probes one row lower (may be -1 at the floor).
  assign w_fit_row = (r_state == S_STEP) ? $signed({1'b0, r_cur_row}) - $signed((ROW_W+1)'(1))
                                         : $signed({1'b0, r_cur_row});

  piece_fit_check #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_fit (
    .i_mask (r_mask),
    .i_row  (w_fit_row),
    .i_col  (r_col),
    .i_map  (r_map),
    .o_fits (w_fits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fin       = 1'b0;
    w_fin_blk   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CHECK;
          w_load      = 1'b1;
        end
      end
      S_CHECK: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (!w_fits) begin
          w_state_nxt = S_DONE;
          w_fin       = 1'b1;
          w_fin_blk   = 1'b1;
        end else begin
          w_state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cur_row != '0 && w_fits) begin
          w_step = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
          w_fin       = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask    <= '0;
      r_col     <= '0;
      r_map     <= '0;
      r_mode    <= 1'b0;
      r_cur_row <= '0;
      r_drop    <= '0;
    end else if (w_load) begin
      r_mask    <= piece_mask;
      r_col     <= anchor_col;
      r_map     <= blocks_exist;
      r_mode    <= mode;
      r_cur_row <= anchor_row;
      r_drop    <= '0;
    end else if (w_step) begin
      r_cur_row <= r_cur_row - ROW_W'(1);
      r_drop    <= r_drop + ROW_W'(1);
    end
  end

  // Results only move on entry to DONE, so an aborted scan leaves the last result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blocked     <= 1'b0;
      r_result_row  <= ROW_W'(ROWS - 1);
      r_drop_rows   <= '0;
      r_result_mode <= 1'b0;
    end else if (w_fin) begin
      r_blocked     <= w_fin_blk;
      r_result_row  <= r_cur_row;
      r_drop_rows   <= r_drop;
      r_result_mode <= r_mode;
    end
  end

  assign busy        = (r_state == S_CHECK) || (r_state == S_STEP);
  assign done        = (r_state == S_DONE);
  assign blocked     = r_blocked;
  assign result_row  = r_result_row;
  assign drop_rows   = r_drop_rows;
  assign result_mode = r_result_mode;

endmodule

// File: tb/tb_drop_scanner.sv
// Directed bench for drop_scanner: a search-based drop model predicts every
// result, a compare process checks it on each done pulse, literals pin the model.
module tb_drop_scanner;

  localparam int COLS   = 10;
  localparam int ROWS   = 20;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int SC     = 6;
  localparam int SR     = 8;
  localparam int SROW_W = $clog2(SR);
  localparam int SCOL_W = $clog2(SC);
  localparam int MAXM   = COLS * ROWS;

  logic                 clk;
  logic                 rst_n;
  logic                 start, abort, mode;
  logic [COLS*ROWS-1:0] blocks_exist;
  logic [15:0]          piece_mask;
  logic [ROW_W-1:0]     anchor_row;
  logic [COL_W-1:0]     anchor_col;
  logic                 busy, done, blocked, result_mode;
  logic [ROW_W-1:0]     result_row, drop_rows;

  logic                 s_start, s_abort, s_mode;
  logic [SC*SR-1:0]     s_map;
  logic [15:0]          s_mask;
  logic [SROW_W-1:0]    s_arow;
  logic [SCOL_W-1:0]    s_acol;
  logic                 s_busy, s_done, s_blocked, s_result_mode;
  logic [SROW_W-1:0]    s_result_row, s_drop_rows;

  int n_pass  = 0;
  int n_total = 0;
  int n_done  = 0;
  bit m_pend  = 1'b0;
  int m_blk, m_row, m_drop, m_mode;

  drop_scanner #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .blocks_exist(blocks_exist), .piece_mask(piece_mask),
    .anchor_row(anchor_row), .anchor_col(anchor_col),
    .busy(busy), .done(done), .blocked(blocked),
    .result_row(result_row), .drop_rows(drop_rows), .result_mode(result_mode)
  );

  drop_scanner #(.COLS(SC), .ROWS(SR)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .mode(s_mode),
    .blocks_exist(s_map), .piece_mask(s_mask),
    .anchor_row(s_arow), .anchor_col(s_acol),
    .busy(s_busy), .done(s_done), .blocked(s_blocked),
    .result_row(s_result_row), .drop_rows(s_drop_rows), .result_mode(s_result_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic bit fits_at(input bit [MAXM-1:0] map, input bit [15:0] mask,
                                 input int r, input int c, input int cols, input int rows);
    for (int k = 0; k < 16; k++) begin
      int cr, cc;
      cr = r - k / 4;
      cc = c + k % 4;
      if (mask[k]) begin
        if (cr < 0 || cr >= rows || cc >= cols) return 1'b0;
        if (map[cr * cols + cc]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic void model(input bit [MAXM-1:0] map, input bit [15:0] mask,
                                input int ar, input int ac, input int cols, input int rows,
                                output int blk, output int row, output int drop);
    int r;
    if (!fits_at(map, mask, ar, ac, cols, rows)) begin
      blk = 1; row = ar; drop = 0;
      return;
    end
    r = ar;
    while (r > 0 && fits_at(map, mask, r - 1, ac, cols, rows)) r--;
    blk = 0; row = r; drop = ar - r;
  endfunction

  // Compare process: every done pulse of the main DUT must match the model prediction.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        n_done++;
        if (!m_pend) chk("cmp.unexpected_done", 1, 0);
        else begin
          chk("cmp.blocked", int'(blocked), m_blk);
          chk("cmp.row", int'(result_row), m_row);
          chk("cmp.drop", int'(drop_rows), m_drop);
          chk("cmp.mode", int'(result_mode), m_mode);
          m_pend = 1'b0;
        end
      end
    end
  end

  task automatic chk_reset(input string nm);
    chk({nm, ".busy"}, int'(busy), 0);
    chk({nm, ".done"}, int'(done), 0);
    chk({nm, ".blocked"}, int'(blocked), 0);
    chk({nm, ".row"}, int'(result_row), ROWS - 1);
    chk({nm, ".drop"}, int'(drop_rows), 0);
    chk({nm, ".mode"}, int'(result_mode), 0);
  endtask

  task automatic apply(input logic [COLS*ROWS-1:0] map, input logic [15:0] mask,
                       input int ar, input int ac, input logic md, input logic ab);
    @(negedge clk);
    blocks_exist = map; piece_mask = mask;
    anchor_row = ROW_W'(ar); anchor_col = COL_W'(ac);
    mode = md; start = 1'b1; abort = ab;
    model(map, mask, ar, ac, COLS, ROWS, m_blk, m_row, m_drop);
    m_mode = int'(md);
    m_pend = 1'b1;
    @(posedge clk);
  endtask

  // cyc = 1 is the CHECK cycle; poke scrambles inputs and pulses start while busy.
  task automatic wait_done(input bit poke, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0; abort = 1'b0;
        if (poke) begin
          blocks_exist = '1; piece_mask = 16'hFFFF; anchor_row = '0; mode = ~mode;
        end
      end
      if (poke) start = (cyc == 2);
    end while (!done && cyc < 200);
    if (!done) chk("wait_done.timeout", 0, 1);
  endtask

  task automatic run(input string nm, input logic [COLS*ROWS-1:0] map, input logic [15:0] mask,
                     input int ar, input int ac, input logic md,
                     input int e_blk, input int e_row, input int e_drop);
    int cyc;
    apply(map, mask, ar, ac, md, 1'b0);
    chk({nm, ".model_row"}, m_row, e_row);
    chk({nm, ".model_drop"}, m_drop, e_drop);
    wait_done(1'b0, cyc);
    chk({nm, ".latency"}, cyc, (e_blk != 0) ? 2 : e_drop + 3);
    chk({nm, ".blocked"}, int'(blocked), e_blk);
    chk({nm, ".row"}, int'(result_row), e_row);
    chk({nm, ".drop"}, int'(drop_rows), e_drop);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, ".pulse"}, int'(done), 0);
    @(negedge clk);
    chk({nm, ".start_in_done_ignored"}, int'(busy), 0);
    chk({nm, ".hold"}, int'(result_row), e_row);
  endtask

  initial begin
    logic [COLS*ROWS-1:0] map;
    bit   [MAXM-1:0]      sm;
    int cyc, n0, e_blk, e_row, e_drop;

    start = 1'b0; abort = 1'b0; mode = 1'b0; blocks_exist = '0;
    piece_mask = '0; anchor_row = '0; anchor_col = '0;
    s_start = 1'b0; s_abort = 1'b0; s_mode = 1'b0; s_map = '0;
    s_mask = '0; s_arow = '0; s_acol = '0;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk_reset("reset");
    chk("reset.small_row", int'(s_result_row), SR - 1);
    @(negedge clk);
    rst_n = 1'b1;

    map = '0;
    run("o_empty", map, 16'h0033, 19, 4, 1'b0, 0, 1, 18);
    for (int i = 40; i < 50; i++) map[i] = 1'b1;
    run("i_vert", map, 16'h1111, 19, 0, 1'b1, 0, 8, 11);
    map = '0;
    map[19 * COLS + 5] = 1'b1;
    run("blocked_start", map, 16'h0001, 19, 5, 1'b0, 1, 19, 0);
    map = '0;
    run("right_edge", map, 16'h0003, 19, 9, 1'b1, 1, 19, 0);
    run("empty_mask", map, 16'h0000, 12, 3, 1'b0, 0, 0, 12);
    map[5 * COLS + 3] = 1'b1;
    run("overhang", map, 16'h0072, 15, 2, 1'b1, 0, 7, 8);

    // Abort on the 4th STEP cycle with a stray start in between.
    n0 = n_done;
    map = '0;
    apply(map, 16'h0033, 19, 0, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    chk("abort.busy_check", int'(busy), 1);
    @(negedge clk); start = 1'b1; piece_mask = 16'hFFFF;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); abort = 1'b1;
    chk("abort.busy_step4", int'(busy), 1);
    @(negedge clk); abort = 1'b0; m_pend = 1'b0;
    chk("abort.idle", int'(busy), 0);
    chk("abort.row_kept", int'(result_row), 7);
    chk("abort.drop_kept", int'(drop_rows), 8);
    repeat (25) @(negedge clk);
    chk("abort.no_done", n_done - n0, 0);

    // Start with abort in IDLE is accepted; later input changes must not leak in.
    apply(map, 16'h0001, 10, 9, 1'b1, 1'b1);
    wait_done(1'b1, cyc);
    chk("restart.latency", cyc, 13);
    chk("restart.blocked", int'(blocked), 0);
    chk("restart.row", int'(result_row), 0);
    chk("restart.drop", int'(drop_rows), 10);
    chk("restart.mode", int'(result_mode), 1);
    @(negedge clk);
    start = 1'b0;
    chk("restart.one_done", n_done - n0, 1);

    // Reset in the middle of a scan.
    map = '0;
    apply(map, 16'h0001, 15, 0, 1'b1, 1'b0);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; m_pend = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk); rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("midrst.no_done", n_done - n0, 1);
    chk("midrst.idle", int'(busy), 0);

    // 6x8 board instance.
    @(negedge clk);
    s_map = '0; s_mask = 16'h0001; s_arow = SROW_W'(7); s_acol = SCOL_W'(2);
    s_mode = 1'b1; s_start = 1'b1;
    sm = '0;
    model(sm, 16'h0001, 7, 2, SC, SR, e_blk, e_row, e_drop);
    chk("small.model_row", e_row, 0);
    chk("small.model_drop", e_drop, 7);
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      s_start = 1'b0;
      if (cyc == 1) s_mode = 1'b0;
    end while (!s_done && cyc < 100);
    chk("small.latency", cyc, 10);
    chk("small.blocked", int'(s_blocked), 0);
    chk("small.row", int'(s_result_row), 0);
    chk("small.drop", int'(s_drop_rows), 7);
    chk("small.mode", int'(s_result_mode), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
